xor_stream_unit: RTL and testbench
==================================

Name: xor_stream_unit

Overview:
- Parametrised, registered successor to the plain two-operand XOR primitive.
- Accepts operand pairs over a valid/ready stream and produces XOR results through a one-deep output register with backpressure.
- Operates in one of three modes, selected per frame:
  - PAIR: bitwise A^B.
  - ACCUM: XOR-reduction of a whole frame.
  - DIFF: delta encoding, A XOR previous A.
- Sits between data-path sources and checksum/scrambler consumers.

Parameters:
- DATA_WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 8, width of the beat counter reported with each result (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  operation select: 00 PAIR, 01 ACCUM, 10 DIFF, 11 reserved (behaves as PAIR). Sampled on the first beat of a frame.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_a  input  DATA_WIDTH  operand A.
- in_b  input  DATA_WIDTH  operand B (ignored in DIFF).
- in_last  input  1  beat is the final beat of the current frame.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_y  output  DATA_WIDTH  result word.
- out_parity  output  1  XOR-reduction of out_y.
- out_count  output  CNT_W  beat number (PAIR/DIFF) or frame beat total (ACCUM), saturating.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_y=0, out_parity=0, out_count=0.
  - Accumulator=0, prev_a=0, beat counter=0, state=S_IDLE, latched mode=PAIR.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational; the only combinational path).
  - While in_valid=1 and not yet accepted, the producer holds in_* stable.
  - out_y/out_parity/out_count are held stable while out_valid && !out_ready.
- Latency: a beat that produces a result is accepted at edge N; out_valid=1 with the result after edge N. Full throughput is 1 beat/cycle when out_ready=1.
- States:
  - S_IDLE: no frame open. On an accepted beat, latch mode, set counter=1. If in_last=0, go to S_FRAME; otherwise stay in S_IDLE.
  - S_FRAME: frame open. Use the latched mode and ignore the mode port. Each accepted beat increments the counter (saturating at 2^CNT_W-1). An accepted beat with in_last=1 returns to S_IDLE.
- PAIR:
  - Every accepted beat loads out_y=in_a^in_b and out_count=beat number within the frame.
- ACCUM:
  - Non-last beats: acc <= acc^in_a^in_b; no result is produced.
  - Last beat: out_y = acc^in_a^in_b, out_count = total beats; then acc <= 0.
  - A single-beat frame (in_last on the first beat) gives out_y=in_a^in_b, out_count=1.
- DIFF:
  - Every accepted beat loads out_y = in_a^prev_a, then prev_a <= in_a.
  - On the last beat, prev_a <= 0 after use, so the next frame starts from 0.
- out_parity = ^out_y, registered together with out_y.
- Simultaneous consume and accept in the same cycle: the result register loads the new result, so out_valid stays 1.
- A consume with no result-producing accept (ACCUM non-last beat, or no beat) clears out_valid.
- Counter saturation: out_count holds at all-ones, and frame behaviour is otherwise unaffected.
- Reset mid-frame discards the partial frame and any pending result. No output appears for it after reset.

Decomposition:
- Package xor_stream_pkg holds:
  - Enum xor_mode_e: MODE_PAIR, MODE_ACCUM, MODE_DIFF, MODE_RSVD.
  - Enum xor_state_e: S_IDLE, S_FRAME.
  - Function that maps MODE_RSVD to MODE_PAIR.
- One sub-module, xor_out_stage: the parametrised result register with valid/ready and load/hold logic (out_y, out_parity, out_count). It is instantiated once.

Test Plan:
- Reset then PAIR, out_ready=1: beats (A=0x5A,B=0xFF),(0x0F,0xF0) with last on the 2nd -> out_y 0xA5 (parity 0, count 1) then 0xFF (parity 0, count 2), each one cycle after acceptance.
- ACCUM 3-beat frame: (0x01,0x02),(0x04,0x08),(0x10,0x20 last) -> exactly one result, out_y=0x3F, out_parity=0, count=3; next frame's accumulator starts at 0.
- DIFF: in_a=0x10,0x30,0x30(last), then new frame 0x07 -> out_y 0x10,0x20,0x00, then 0x07.
- Backpressure in PAIR: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 after the first result, out_y held; out_ready=1 with a continuous stream -> one result per cycle, no drop or duplication.
- Mode port toggled mid ACCUM frame to PAIR -> ignored until last beat; next frame uses new mode. mode=11 -> PAIR results.
- rst pulsed in S_FRAME (ACCUM, 2 beats in) and with out_valid=1 -> out_valid=0 and outputs 0 immediately (async); the following 1-beat ACCUM frame (0xAA,0x00,last) gives out_y=0xAA, count=1.
- CNT_W=2 in a 5-beat PAIR frame -> counts 1,2,3,3,3.

Source files
------------

// File: rtl/xor_stream_pkg.sv
// Shared types for the xor_stream_unit slice: operating modes, frame states
// and the reserved-mode mapping.
package xor_stream_pkg;

    typedef enum logic [1:0] {
        MODE_PAIR  = 2'b00,
        MODE_ACCUM = 2'b01,
        MODE_DIFF  = 2'b10,
        MODE_RSVD  = 2'b11
    } xor_mode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } xor_state_e;

    // The reserved encoding behaves exactly like PAIR.
    function automatic xor_mode_e resolve_mode(input logic [1:0] m);
        return (m == 2'(MODE_RSVD)) ? MODE_PAIR : xor_mode_e'(m);
    endfunction

endpackage

// File: rtl/xor_out_stage.sv
// One-deep result register: holds out_y/out_parity/out_count until consumed,
// and reloads in the same cycle as a consume for full throughput.
module xor_out_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_y,
    input  logic [CNT_W-1:0]      load_count,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  out_parity,
    output logic [CNT_W-1:0]      out_count
);

    // Valid/ready: a word moves when valid && ready on the same rising edge;
    // the register may take a new word whenever it is empty or being drained.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_parity <= 1'b0;
            out_count  <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_y      <= load_y;
            out_parity <= ^load_y;
            out_count  <= load_count;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/xor_stream_unit.sv
// Streaming XOR unit: PAIR (A^B), ACCUM (frame XOR-reduction) and DIFF
// (A ^ previous A) modes, selected on the first beat of each frame.
module xor_stream_unit
    import xor_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  out_parity,
    output logic [CNT_W-1:0]      out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    xor_state_e            state;
    xor_mode_e             mode_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] prev_a;
    logic [CNT_W-1:0]      cnt;

    xor_mode_e             eff_mode;
    logic                  accept;
    logic                  produce;
    logic [CNT_W-1:0]      cnt_next;
    logic [DATA_WIDTH-1:0] result;

    always_comb begin
        eff_mode = (state == S_IDLE) ? resolve_mode(mode) : mode_q;
        accept   = in_valid && in_ready;
        if (state == S_IDLE)
            cnt_next = CNT_W'(1);
        else
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        case (eff_mode)
            MODE_ACCUM: result = acc ^ in_a ^ in_b;
            MODE_DIFF:  result = in_a ^ prev_a;
            default:    result = in_a ^ in_b;
        endcase
        // ACCUM only emits on the closing beat of its frame.
        produce = accept && ((eff_mode != MODE_ACCUM) || in_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_q <= MODE_PAIR;
            acc    <= '0;
            prev_a <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mode_q <= eff_mode;
            cnt    <= cnt_next;
            state  <= in_last ? S_IDLE : S_FRAME;
            if (eff_mode == MODE_ACCUM)
                acc <= in_last ? '0 : (acc ^ in_a ^ in_b);
            if (eff_mode == MODE_DIFF)
                prev_a <= in_last ? '0 : in_a;
        end
    end

    xor_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_out (
        .clk        (clk),
        .rst        (rst),
        .load       (produce),
        .load_y     (result),
        .load_count (cnt_next),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_parity (out_parity),
        .out_count  (out_count)
    );

endmodule

// File: tb/tb_xor_stream_unit.sv
// Directed bench for xor_stream_unit: a frame-level reference model with a
// per-cycle compare, plus literal result checks for each scenario.
module tb_xor_stream_unit;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;

    logic          in_ready, out_valid, out_parity;
    logic [DW-1:0] out_y;
    logic [7:0]    out_count;
    logic          in_ready2, out_valid2, out_parity2;
    logic [DW-1:0] out_y2;
    logic [1:0]    out_count2;

    int n_tests = 0;
    int n_fail  = 0;

    // clock / reset
    always #5 clk = ~clk;

    xor_stream_unit #(.DATA_WIDTH(DW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_parity(out_parity), .out_count(out_count)
    );

    xor_stream_unit #(.DATA_WIDTH(DW), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_y(out_y2), .out_parity(out_parity2), .out_count(out_count2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // reference model: pending results in a queue, frame state as plain integers
    logic [DW-1:0] exp_q[$];
    int            cnt_q[$];
    bit            m_open = 1'b0;
    logic [1:0]    m_mode = 2'd0;
    int            m_beat = 0;
    logic [DW-1:0] m_acc = '0;
    logic [DW-1:0] m_prev = '0;
    bit            m_take;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            cnt_q.delete();
            m_open = 1'b0;
            m_beat = 0;
            m_acc  = '0;
            m_prev = '0;
        end else begin
            m_take = in_valid && ((exp_q.size() == 0) || out_ready);
            if (exp_q.size() != 0 && out_ready) begin
                void'(exp_q.pop_front());
                void'(cnt_q.pop_front());
            end
            if (m_take) begin
                if (!m_open) begin
                    m_mode = (mode == 2'd3) ? 2'd0 : mode;
                    m_beat = 0;
                end
                m_beat++;
                if (m_mode == 2'd1) begin
                    m_acc = m_acc ^ in_a ^ in_b;
                    if (in_last) begin
                        exp_q.push_back(m_acc);
                        cnt_q.push_back(m_beat);
                        m_acc = '0;
                    end
                end else if (m_mode == 2'd2) begin
                    exp_q.push_back(in_a ^ m_prev);
                    cnt_q.push_back(m_beat);
                    m_prev = in_last ? '0 : in_a;
                end else begin
                    exp_q.push_back(in_a ^ in_b);
                    cnt_q.push_back(m_beat);
                end
                m_open = !in_last;
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready_w2", in_ready2, (exp_q.size() == 0) || out_ready);
            chk("out_valid_w2", out_valid2, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("out_y", out_y, exp_q[0]);
                chk("out_parity", out_parity, ^exp_q[0]);
                chk("out_count", out_count, sat(cnt_q[0], 8));
                chk("out_y_w2", out_y2, exp_q[0]);
                chk("out_count_w2", out_count2, sat(cnt_q[0], 2));
            end
        end
    end

    // log of consumed results for the literal checks
    logic [DW-1:0] mon_y[$];
    logic          mon_p[$];
    int            mon_c[$];
    int            mon_c2[$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_y.push_back(out_y);
            mon_p.push_back(out_parity);
            mon_c.push_back(int'(out_count));
            mon_c2.push_back(int'(out_count2));
        end
    end

    // driver tasks
    task automatic send(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic last);
        int t;
        bit ok;
        t = 0;
        mode = m; in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            t++;
            if (t > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: beat a=0x%0h never accepted", a);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input logic [DW-1:0] y, input logic p, input int c, input int c2);
        if (mon_y.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL result_missing: no result logged, expected y=0x%0h", y);
        end else begin
            chk("lit_y", mon_y.pop_front(), y);
            chk("lit_parity", mon_p.pop_front(), p);
            chk("lit_count", mon_c.pop_front(), c);
            chk("lit_count_w2", mon_c2.pop_front(), c2);
        end
    endtask

    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_parity", out_parity, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_valid_w2", out_valid2, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    bit bp_done;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_y", out_y, 0);
        chk("reset_out_parity", out_parity, 0);
        chk("reset_out_count", out_count, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // PAIR, result one cycle after acceptance
        send(2'd0, 8'h5A, 8'hFF, 1'b0);
        chk("pair_latency_y", out_y, 8'hA5);
        chk("pair_latency_valid", out_valid, 1);
        send(2'd0, 8'h0F, 8'hF0, 1'b1);
        idle(3);
        expect_res(8'hA5, 1'b0, 1, 1);
        expect_res(8'hFF, 1'b0, 2, 2);
        chk("pair_log_empty", mon_y.size(), 0);

        // ACCUM: one result per frame, accumulator restarts at zero
        send(2'd1, 8'h01, 8'h02, 1'b0);
        send(2'd1, 8'h04, 8'h08, 1'b0);
        send(2'd1, 8'h10, 8'h20, 1'b1);
        send(2'd1, 8'h11, 8'h22, 1'b0);
        send(2'd1, 8'h44, 8'h00, 1'b1);
        idle(3);
        expect_res(8'h3F, 1'b0, 3, 3);
        expect_res(8'h77, 1'b0, 2, 2);
        chk("accum_log_empty", mon_y.size(), 0);

        // DIFF: in_b ignored, prev_a cleared between frames
        send(2'd2, 8'h10, 8'hFF, 1'b0);
        send(2'd2, 8'h30, 8'hAB, 1'b0);
        send(2'd2, 8'h30, 8'h00, 1'b1);
        send(2'd2, 8'h07, 8'h55, 1'b1);
        idle(3);
        expect_res(8'h10, 1'b1, 1, 1);
        expect_res(8'h20, 1'b1, 2, 2);
        expect_res(8'h00, 1'b0, 3, 3);
        expect_res(8'h07, 1'b1, 1, 1);

        // backpressure: first result held while out_ready is low
        out_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                send(2'd0, 8'h01, 8'h02, 1'b0);
                send(2'd0, 8'h03, 8'h04, 1'b0);
                send(2'd0, 8'h05, 8'h06, 1'b1);
                bp_done = 1'b1;
            end
        join_none
        repeat (5) @(posedge clk);
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_y_held", out_y, 8'h03);
        chk("bp_out_count_held", out_count, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !bp_done; i++) @(posedge clk);
        #1;
        chk("bp_stream_done", bp_done, 1);
        idle(3);
        expect_res(8'h03, 1'b0, 1, 1);
        expect_res(8'h07, 1'b1, 2, 2);
        expect_res(8'h03, 1'b0, 3, 3);
        chk("bp_log_empty", mon_y.size(), 0);

        // continuous 5-beat PAIR frame: one result per cycle, narrow counter saturates
        for (int i = 1; i <= 5; i++) send(2'd0, 8'(i), 8'hF0, i == 5);
        idle(3);
        expect_res(8'hF1, 1'b1, 1, 1);
        expect_res(8'hF2, 1'b1, 2, 2);
        expect_res(8'hF3, 1'b0, 3, 3);
        expect_res(8'hF4, 1'b1, 4, 3);
        expect_res(8'hF5, 1'b0, 5, 3);

        // mode port ignored mid-frame; new mode and reserved mode on later frames
        send(2'd1, 8'h0F, 8'h00, 1'b0);
        send(2'd0, 8'hF0, 8'h00, 1'b0);
        send(2'd0, 8'h00, 8'h01, 1'b1);
        send(2'd0, 8'h12, 8'h34, 1'b1);
        send(2'd3, 8'hC3, 8'h0F, 1'b1);
        idle(3);
        expect_res(8'hFE, 1'b1, 3, 3);
        expect_res(8'h26, 1'b1, 1, 1);
        expect_res(8'hCC, 1'b0, 1, 1);

        // reset in the middle of an ACCUM frame
        send(2'd1, 8'h55, 8'h00, 1'b0);
        send(2'd1, 8'h66, 8'h00, 1'b0);
        pulse_rst();
        send(2'd1, 8'hAA, 8'h00, 1'b1);
        idle(3);
        expect_res(8'hAA, 1'b0, 1, 1);
        chk("rst_frame_log_empty", mon_y.size(), 0);

        // reset while a result is pending: it never appears
        out_ready = 1'b0;
        send(2'd0, 8'h3C, 8'h00, 1'b1);
        idle(2);
        chk("pending_before_rst", out_valid, 1);
        pulse_rst();
        out_ready = 1'b1;
        idle(3);
        chk("pending_discarded", mon_y.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
